// File: rtl/modinv_top.sv
// Multi-cycle modular inverse: smallest x in [1,m-1] with (a*x) % m == 1.
// Reduces a mod m by subtraction, then walks candidates keeping a'*x mod m.
module modinv_top #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] data0_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [WIDTH-1:0] result_o,
    output logic             error_o,
    output logic             out_valid_o,
    input  logic             out_ready_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REDUCE,
        S_SEARCH,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_r;
    logic [WIDTH-1:0] r_result;
    logic             r_error;
    logic             r_out_valid;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_sum_red;

    // r + a' needs one extra bit; both are below m, so one subtract wraps it
    assign w_sum     = {1'b0, r_r} + {1'b0, r_acc};
    assign w_sum_red = (w_sum >= {1'b0, r_m}) ? (w_sum - {1'b0, r_m}) : w_sum;

    assign in_ready_o  = (r_state == S_IDLE) && rst_ni;
    assign result_o    = r_result;
    assign error_o     = r_error;
    assign out_valid_o = r_out_valid;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_m         <= '0;
            r_acc       <= '0;
            r_x         <= '0;
            r_r         <= '0;
            r_result    <= '0;
            r_error     <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid_i) begin
                        r_m   <= data1_i;
                        r_acc <= data0_i;
                        if (data1_i < WIDTH'(2)) begin
                            r_result    <= '0;
                            r_error     <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_state <= S_REDUCE;
                        end
                    end
                end
                S_REDUCE: begin
                    if (r_acc >= r_m) begin
                        r_acc <= r_acc - r_m;
                    end else begin
                        r_x     <= WIDTH'(1);
                        r_r     <= r_acc;
                        r_state <= S_SEARCH;
                    end
                end
                S_SEARCH: begin
                    if (r_r == WIDTH'(1)) begin
                        r_result    <= r_x;
                        r_error     <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (r_x == (r_m - WIDTH'(1))) begin
                        r_result    <= '0;
                        r_error     <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_x <= r_x + WIDTH'(1);
                        r_r <= w_sum_red[WIDTH-1:0];
                    end
                end
                S_DONE: begin
                    if (out_ready_i) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_modinv_top.sv
// Directed bench for modinv_top with an expected-result queue.
// Latency is counted in clock edges after the accept edge.
module tb_modinv_top;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [7:0] data0_i;
    logic [7:0] data1_i;
    logic       in_valid_i;
    logic       in_ready_o;
    logic [7:0] result_o;
    logic       error_o;
    logic       out_valid_o;
    logic       out_ready_i;

    typedef struct {
        logic [7:0] res;
        logic       err;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc = 0;

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    modinv_top #(.WIDTH(8)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .data0_i    (data0_i),
        .data1_i    (data1_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .result_o   (result_o),
        .error_o    (error_o),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
        end
    endtask

    // Brute-force reference; m<2 results appear the cycle after accept
    function automatic exp_t model(input int a, input int m);
        exp_t e;
        e.res = 8'd0;
        e.err = 1'b1;
        e.lat = 0;
        if (m < 2) return e;
        e.lat = 1 + a / m + (m - 1);
        for (int x = 1; x < m; x++) begin
            if (((a * x) % m) == 1) begin
                e.res = 8'(x);
                e.err = 1'b0;
                e.lat = 1 + a / m + x;
                break;
            end
        end
        return e;
    endfunction

    task automatic send(input logic [7:0] a, input logic [7:0] m);
        @(negedge clk_i);
        chk("in_ready_before_accept", 32'(in_ready_o), 32'd1);
        data0_i    = a;
        data1_i    = m;
        in_valid_i = 1'b1;
        sb.push_back(model(int'(a), int'(m)));
        @(negedge clk_i);
        acc_cyc    = cyc;
        in_valid_i = 1'b0;
        data0_i    = 8'($urandom);
        data1_i    = 8'($urandom);
    endtask

    task automatic receive(input string tag, input int stall, input bit hold);
        exp_t e;
        int   guard = 0;
        while (!out_valid_o && guard < 1200) begin
            @(negedge clk_i);
            guard++;
        end
        if (!out_valid_o) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        if (sb.size() == 0) begin
            chk({tag, "_unexpected"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_lat"}, 32'(cyc - acc_cyc), 32'(e.lat));
        chk({tag, "_res"}, 32'(result_o), 32'(e.res));
        chk({tag, "_err"}, 32'(error_o), 32'(e.err));
        if (hold) begin
            @(negedge clk_i);
            chk({tag, "_pulse1"}, 32'(out_valid_o), 32'd0);
            chk({tag, "_idle"}, 32'(in_ready_o), 32'd1);
        end else begin
            repeat (stall) begin
                @(negedge clk_i);
                chk({tag, "_hold_v"}, 32'(out_valid_o), 32'd1);
                chk({tag, "_hold_res"}, 32'(result_o), 32'(e.res));
                chk({tag, "_hold_err"}, 32'(error_o), 32'(e.err));
                chk({tag, "_hold_rdy"}, 32'(in_ready_o), 32'd0);
            end
            out_ready_i = 1'b1;
            @(negedge clk_i);
            out_ready_i = 1'b0;
            chk({tag, "_hs_v"}, 32'(out_valid_o), 32'd0);
            chk({tag, "_hs_rdy"}, 32'(in_ready_o), 32'd1);
        end
        chk({tag, "_keep_res"}, 32'(result_o), 32'(e.res));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int spurious;
        rst_ni      = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        data0_i     = 8'd0;
        data1_i     = 8'd0;
        repeat (3) @(negedge clk_i);
        chk("rst_valid", 32'(out_valid_o), 32'd0);
        chk("rst_ready", 32'(in_ready_o), 32'd0);
        chk("rst_res", 32'(result_o), 32'd0);
        chk("rst_err", 32'(error_o), 32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("post_rst_ready", 32'(in_ready_o), 32'd1);

        out_ready_i = 1'b1;
        send(8'd3, 8'd7);
        receive("a3m7", 0, 1'b1);
        out_ready_i = 1'b0;

        send(8'd20, 8'd7);
        receive("a20m7", 2, 1'b0);
        send(8'd4, 8'd6);
        receive("a4m6", 0, 1'b0);
        send(8'd0, 8'd9);
        receive("a0m9", 0, 1'b0);
        send(8'd9, 8'd0);
        receive("m0", 5, 1'b0);
        send(8'd200, 8'd1);
        receive("m1", 5, 1'b0);

        // Operands offered while busy must be ignored
        send(8'd255, 8'd254);
        in_valid_i = 1'b1;
        data0_i    = 8'd2;
        data1_i    = 8'd5;
        #1 chk("busy_ready0", 32'(in_ready_o), 32'd0);
        @(negedge clk_i);
        chk("busy_ready1", 32'(in_ready_o), 32'd0);
        in_valid_i = 1'b0;
        receive("a255m254", 0, 1'b0);
        send(8'd2, 8'd5);
        receive("a2m5", 0, 1'b0);

        // Abort a long search with a one-cycle reset
        send(8'd5, 8'd251);
        repeat (20) @(negedge clk_i);
        rst_ni = 1'b0;
        #1 chk("midrst_ready", 32'(in_ready_o), 32'd0);
        sb.delete();
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1 chk("midrst_ready_after", 32'(in_ready_o), 32'd1);
        spurious = 0;
        repeat (10) begin
            @(negedge clk_i);
            if (out_valid_o) spurious++;
        end
        chk("midrst_no_valid", 32'(spurious), 32'd0);
        send(8'd2, 8'd3);
        receive("a2m3", 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
